dbg_io_unit: RTL

Debug I/O slave on the `dbg_membus` port of `mmio_controller`, at `MMAP_DBG_ADDR`. Accepts printf-character and exit-flag writes from the core and buffers the characters in a TX FIFO. The FIFO drains at a programmed rate to a character output. The block reports the exit result only after every earlier character has been emitted, so simulation output stays in program order.

---
 rtl/dbg_io_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dbg_io_unit.sv
// Debug I/O slave: printf FIFO drained at a fixed rate, exit reported in order.
// `DBG_IO_RX_EN enables the rx buffer; `DBG_IO_SIM_REPORT enables console output.
module dbg_io_unit #(
  parameter int FIFO_DEPTH = 8,
  parameter int DRAIN_DIV  = 4,
  parameter int XLEN       = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            membus_valid,
  output logic            membus_ready,
  input  logic [XLEN-1:0] membus_addr,
  input  logic            membus_wen,
  input  logic [63:0]     membus_wdata,
  input  logic [7:0]      membus_wmask,
  output logic            membus_rvalid,
  output logic [63:0]     membus_rdata,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  output logic            done,
  output logic            test_success
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DRAIN_DIV - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [63:0]   exit_code_q, exit_code_d;
  logic          rvalid_q, rvalid_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [7:0]    rx_char_q, rx_char_d;
  logic          rx_full_q, rx_full_d;

  logic exit_pending, fifo_empty, fifo_full;
  logic accept, is_printf, is_exit;
  logic push, pop, rd_acc;
  logic unused_in;

  assign exit_pending = (state_q != S_RUN);
  assign fifo_empty   = (cnt_q == '0);
  assign fifo_full    = (cnt_q == FULL_CNT);
  assign membus_ready = !fifo_full && !exit_pending;
  assign accept       = membus_valid && membus_ready;
  assign is_printf    = membus_wen &&
                        (membus_wdata[63:44] == 20'h01010);
  assign is_exit      = membus_wen && !is_printf &&
                        membus_wdata[0];
  assign push         = accept && is_printf;
  assign rd_acc       = accept && !membus_wen;
  assign pop          = !fifo_empty && (div_q == DIV_LAST);

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    div_d       = (fifo_empty || pop) ? '0 : div_q + DW'(1);
    exit_code_d = exit_code_q;
    state_d     = state_q;
    rvalid_d    = accept;
    rdata_d     = '0;
    unique case (state_q)
      S_RUN: begin
        if (accept && is_exit) begin
          exit_code_d = membus_wdata;
          state_d     = S_FLUSH;
        end
      end
      // last char must leave before done is raised
      S_FLUSH: if (fifo_empty && !pop) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
    if (rd_acc) begin
      rdata_d[8:0]   = {rx_full_q, rx_char_q};
      rdata_d[23:16] = 8'(cnt_q);
      rdata_d[32]    = exit_pending;
    end
  end

`ifdef DBG_IO_RX_EN
  logic rx_load;
  assign rx_load   = rx_valid && (!rx_full_q || rd_acc);
  assign rx_char_d = rx_load ? rx_data : rx_char_q;
  assign rx_full_d = rx_load ? 1'b1 : (rd_acc ? 1'b0 : rx_full_q);
  assign unused_in = ^{membus_addr, membus_wmask};
`else
  assign rx_char_d = '0;
  assign rx_full_d = 1'b0;
  assign unused_in = ^{membus_addr, membus_wmask, rx_valid, rx_data};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      div_q       <= '0;
      exit_code_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rx_char_q   <= '0;
      rx_full_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      exit_code_q <= exit_code_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rx_char_q   <= rx_char_d;
      rx_full_q   <= rx_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= membus_wdata[7:0];
  end

  assign membus_rvalid = rvalid_q;
  assign membus_rdata  = rdata_q;
  assign tx_valid      = pop;
  assign tx_data       = pop ? mem_q[rd_ptr_q] : '0;
  assign done          = (state_q == S_DONE);
  assign test_success  = done && (exit_code_q == 64'h1);

`ifdef DBG_IO_SIM_REPORT
  always @(posedge clk) begin
    if (rst && tx_valid) $write("%c", tx_data);
    if (rst && state_q == S_FLUSH && state_d == S_DONE) begin
      if (exit_code_q == 64'h1) $display("test success!");
      else $display("test failed!");
      $display("exit_code = %h", exit_code_q);
      $finish;
    end
  end
`endif

endmodule
